// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for multicycle_alu and its multiply/divide engine:
// opcode constants, the engine state encoding, the default word size, and a
// decode helper that says which opcodes the multi-cycle engine owns.
// Build option: MULTICYCLE_ALU_DIVIDE_EN adds DIV/DIVU to the engine's set.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int unsigned ALU_WORD_SIZE = 32;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MFHI  = 4'b1101;
  localparam logic [3:0] OP_MFLO  = 4'b1110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

  // True for opcodes handled by the iterative engine.
  function automatic logic op_is_muldiv(input logic [3:0] op);
    logic r;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MULTICYCLE_ALU_DIVIDE_EN
      OP_DIV, OP_DIVU:   r = 1'b1;
`endif
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_muldiv.sv
// -----------------------------------------------------------------------------
// alu_muldiv
// Iterative multiply (radix-2 shift-add) and, when MULTICYCLE_ALU_DIVIDE_EN is
// defined, restoring divide. Owns the iteration counter, shift registers, sign
// fix-up and the HI/LO result registers.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (clears HI/LO)
//   start_i          accept a mul/div op (only asserted while idle)
//   op_i[1:0]        bit0: unsigned, bit1: divide
//   a_i, b_i         operands, sampled with start_i
//   busy_o           engine occupied (ITER or FIX)
//   done_o           high during FIX: HI/LO are written at the coming edge
//   hi_o, lo_o       architectural HI/LO
//   lo_fix_o         value LO receives at the FIX edge
// -----------------------------------------------------------------------------
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ALU_WORD_SIZE
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WORD_SIZE-1:0] a_i,
  input  logic [WORD_SIZE-1:0] b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [WORD_SIZE-1:0] hi_o,
  output logic [WORD_SIZE-1:0] lo_o,
  output logic [WORD_SIZE-1:0] lo_fix_o
);
  localparam int unsigned W  = WORD_SIZE;
  localparam int unsigned CW = $clog2(W + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [W-1:0]  ZERO_W   = {W{1'b0}};

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic [W:0]     acc_q, acc_d;     // partial product high half / remainder
  logic [W-1:0]   sh_q, sh_d;       // multiplier / dividend-quotient shifter
  logic [W-1:0]   opnd_q;           // multiplicand / divisor magnitude
  logic           neg_lo_q;
  logic [W-1:0]   hi_q, lo_q, hi_fix, lo_fix;
  logic           a_neg, b_neg, op_div;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod, prod_fix;
`ifdef MULTICYCLE_ALU_DIVIDE_EN
  logic           div_q, neg_hi_q, dbz_q;
  logic [W-1:0]   a_q, quo, rem;
  logic [W:0]     div_rem_sh, div_trial;
  assign op_div = op_i[1];
`else
  logic           unused_div_sel;
  assign op_div         = 1'b0;
  assign unused_div_sel = op_i[1];
`endif

  // Signed ops work on magnitudes; the sign is restored in FIX.
  assign a_neg = ~op_i[0] & a_i[W-1];
  assign b_neg = ~op_i[0] & b_i[W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -> ITER (W steps) -> FIX -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_i) state_d = ST_ITER; else state_d = ST_IDLE;
      ST_ITER: if (cnt_q == CNT_ONE) state_d = ST_FIX; else state_d = ST_ITER;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy_o = 1'b1;
    done_o = 1'b0;
    case (state_q)
      ST_IDLE: busy_o = 1'b0;
      ST_ITER: busy_o = 1'b1;
      ST_FIX:  done_o = 1'b1;
      default: busy_o = 1'b0;
    endcase
  end

  // One iteration step of the multiplier or divider.
  always_comb begin
    mul_sum = acc_q + {1'b0, (sh_q[0] ? opnd_q : ZERO_W)};
    acc_d   = {1'b0, mul_sum[W:1]};
    sh_d    = {mul_sum[0], sh_q[W-1:1]};
`ifdef MULTICYCLE_ALU_DIVIDE_EN
    div_rem_sh = {acc_q[W-1:0], sh_q[W-1]};
    div_trial  = div_rem_sh - {1'b0, opnd_q};
    if (div_q) begin
      // Restore when the trial subtraction borrows.
      if (!div_trial[W]) begin
        acc_d = div_trial;
        sh_d  = {sh_q[W-2:0], 1'b1};
      end else begin
        acc_d = div_rem_sh;
        sh_d  = {sh_q[W-2:0], 1'b0};
      end
    end else begin
      acc_d = {1'b0, mul_sum[W:1]};
    end
`endif
  end

  // Sign fix-up and special cases applied in the FIX cycle.
  always_comb begin
    prod     = {acc_q[W-1:0], sh_q};
    prod_fix = neg_lo_q ? -prod : prod;
    hi_fix   = prod_fix[2*W-1:W];
    lo_fix   = prod_fix[W-1:0];
`ifdef MULTICYCLE_ALU_DIVIDE_EN
    quo = neg_lo_q ? -sh_q : sh_q;
    rem = neg_hi_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    if (div_q) begin
      if (dbz_q) begin
        lo_fix = {W{1'b1}};
        hi_fix = a_q;
      end else begin
        lo_fix = quo;
        hi_fix = rem;
      end
    end else begin
      lo_fix = prod_fix[W-1:0];
    end
`endif
  end

  // Datapath registers: load at accept, step in ITER, commit HI/LO in FIX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {(W+1){1'b0}};
      sh_q     <= ZERO_W;
      opnd_q   <= ZERO_W;
      neg_lo_q <= 1'b0;
      hi_q     <= ZERO_W;
      lo_q     <= ZERO_W;
`ifdef MULTICYCLE_ALU_DIVIDE_EN
      div_q    <= 1'b0;
      neg_hi_q <= 1'b0;
      dbz_q    <= 1'b0;
      a_q      <= ZERO_W;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            cnt_q    <= CNT_LOAD;
            acc_q    <= {(W+1){1'b0}};
            sh_q     <= a_mag;
            opnd_q   <= b_mag;
            neg_lo_q <= a_neg ^ b_neg;
`ifdef MULTICYCLE_ALU_DIVIDE_EN
            div_q    <= op_div;
            neg_hi_q <= a_neg;              // remainder follows the dividend
            dbz_q    <= (b_i == ZERO_W);
            a_q      <= a_i;
`endif
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q - CNT_ONE;
          acc_q <= acc_d;
          sh_q  <= sh_d;
        end
        ST_FIX: begin
          hi_q <= hi_fix;
          lo_q <= lo_fix;
        end
        default: cnt_q <= {CW{1'b0}};
      endcase
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign lo_fix_o = lo_fix;

endmodule

// File: rtl/multicycle_alu.sv
// -----------------------------------------------------------------------------
// multicycle_alu
// EX-stage ALU with single-cycle logic/arithmetic/compare/MFHI/MFLO and an
// iterative multiply/divide engine (alu_muldiv). All results are registered
// and presented with a one-cycle done_out pulse.
// Build option: MULTICYCLE_ALU_DIVIDE_EN builds DIV/DIVU; otherwise those
// opcodes are illegal single-cycle ops.
// Ports:
//   clk_in, reset_in          clock, synchronous active-high reset
//   start_in, ready_out       request accepted when both are high
//   alu_control_in            opcode, sampled at accept
//   channel_a_in/_b_in        operands, sampled at accept
//   done_out                  one-cycle pulse, result outputs valid
//   alu_result_out, zero_out  result (LO for mul/div) and its zero flag
//   overflow_out              signed overflow for ADD/SUB
//   illegal_out               undefined opcode
// -----------------------------------------------------------------------------
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int unsigned WORD_SIZE = ALU_WORD_SIZE
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 start_in,
  input  logic [3:0]           alu_control_in,
  input  logic [WORD_SIZE-1:0] channel_a_in,
  input  logic [WORD_SIZE-1:0] channel_b_in,
  output logic                 ready_out,
  output logic                 done_out,
  output logic [WORD_SIZE-1:0] alu_result_out,
  output logic                 zero_out,
  output logic                 overflow_out,
  output logic                 illegal_out
);
  localparam int unsigned W = WORD_SIZE;
  localparam logic [W-1:0] ZERO_W = {W{1'b0}};

  logic         accept, is_md, md_busy, md_done;
  logic [W-1:0] md_hi, md_lo, md_lo_fix;
  logic [W-1:0] a, b, sum, diff, sc_result_d;
  logic         sc_ovf_d, sc_ill_d;
  logic [W-1:0] result_q;
  logic         done_q, zero_q, ovf_q, ill_q;

  assign a         = channel_a_in;
  assign b         = channel_b_in;
  assign ready_out = ~md_busy;
  assign accept    = start_in & ready_out;
  assign is_md     = op_is_muldiv(alu_control_in);

  alu_muldiv #(.WORD_SIZE(W)) u_muldiv (
    .clk_i    (clk_in),
    .rst_i    (reset_in),
    .start_i  (accept & is_md),
    .op_i     (alu_control_in[1:0]),
    .a_i      (a),
    .b_i      (b),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .hi_o     (md_hi),
    .lo_o     (md_lo),
    .lo_fix_o (md_lo_fix)
  );

  // Single-cycle datapath.
  always_comb begin
    sum         = a + b;
    diff        = a - b;
    sc_result_d = ZERO_W;
    sc_ovf_d    = 1'b0;
    sc_ill_d    = 1'b0;
    case (alu_control_in)
      OP_AND:  sc_result_d = a & b;
      OP_OR:   sc_result_d = a | b;
      OP_XOR:  sc_result_d = a ^ b;
      OP_NOR:  sc_result_d = ~(a | b);
      OP_ADD: begin
        sc_result_d = sum;
        sc_ovf_d    = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        sc_result_d = diff;
        sc_ovf_d    = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_SLTU: sc_result_d = {{(W-1){1'b0}}, (a < b)};
      OP_SLT:  sc_result_d = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: sc_result_d = md_hi;
      OP_MFLO: sc_result_d = md_lo;
      // Engine-owned opcodes never take this path; DIV/DIVU arrive here
      // only when the divider is not built, and are then illegal.
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: sc_ill_d = 1'b1;
      default: sc_ill_d = 1'b1;
    endcase
  end

  // Output registers: written on a single-cycle accept or an engine FIX edge.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      done_q   <= 1'b0;
      result_q <= ZERO_W;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ill_q  <= 1'b0;
      if (md_done) begin
        done_q   <= 1'b1;
        result_q <= md_lo_fix;
        zero_q   <= (md_lo_fix == ZERO_W);
        ovf_q    <= 1'b0;
      end else if (accept && !is_md) begin
        done_q   <= 1'b1;
        result_q <= sc_result_d;
        zero_q   <= (sc_result_d == ZERO_W);
        ovf_q    <= sc_ovf_d;
        ill_q    <= sc_ill_d;
      end
    end
  end

  assign done_out       = done_q;
  assign alu_result_out = result_q;
  assign zero_out       = zero_q;
  assign overflow_out   = ovf_q;
  assign illegal_out    = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// -----------------------------------------------------------------------------
// tb_multicycle_alu
// Self-checking bench for multicycle_alu (WORD_SIZE = 32). Expected values come
// from a behavioural model using 64-bit integer arithmetic and a HI/LO pair.
// Honours MULTICYCLE_ALU_DIVIDE_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_multicycle_alu;
  localparam int W = 32;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic         start_in;
  logic [3:0]   alu_control_in;
  logic [W-1:0] channel_a_in;
  logic [W-1:0] channel_b_in;
  logic         ready_out;
  logic         done_out;
  logic [W-1:0] alu_result_out;
  logic         zero_out;
  logic         overflow_out;
  logic         illegal_out;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_hi, m_lo;   // model HI/LO

  logic [3:0]   b2b_op [4];
  logic [W-1:0] b2b_exp [4];

  always #5 clk_in = ~clk_in;

  multicycle_alu #(.WORD_SIZE(W)) dut (
    .clk_in         (clk_in),
    .reset_in       (reset_in),
    .start_in       (start_in),
    .alu_control_in (alu_control_in),
    .channel_a_in   (channel_a_in),
    .channel_b_in   (channel_b_in),
    .ready_out      (ready_out),
    .done_out       (done_out),
    .alu_result_out (alu_result_out),
    .zero_out       (zero_out),
    .overflow_out   (overflow_out),
    .illegal_out    (illegal_out)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: result, flags, and HI/LO side effects of one op.
  task automatic ref_model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                           output logic [W-1:0] res, output logic ovf,
                           output logic ill, output logic md);
    longint sx, sy, s, lim;
    logic [63:0] p;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    lim = longint'(1) <<< (W - 1);
    res = '0; ovf = 1'b0; ill = 1'b0; md = 1'b0;
    case (o)
      4'h0: res = x & y;
      4'h1: res = x | y;
      4'h2: begin res = x + y; s = sx + sy; ovf = (s >= lim) || (s < -lim); end
      4'h3: res = {31'b0, (x < y)};
      4'h4: res = x ^ y;
      4'h6: begin res = x - y; s = sx - sy; ovf = (s >= lim) || (s < -lim); end
      4'h7: res = {31'b0, (sx < sy)};
      4'hC: res = ~(x | y);
      4'hD: res = m_hi;
      4'hE: res = m_lo;
      4'h8: begin md = 1'b1; p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
      4'h9: begin md = 1'b1; p = {32'b0, x} * {32'b0, y}; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
`ifdef MULTICYCLE_ALU_DIVIDE_EN
      4'hA: begin
        md = 1'b1;
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin s = sx / sy; m_lo = s[31:0]; s = sx % sy; m_hi = s[31:0]; end
        res = m_lo;
      end
      4'hB: begin
        md = 1'b1;
        if (y == 0) begin m_lo = '1; m_hi = x; end
        else begin m_lo = x / y; m_hi = x % y; end
        res = m_lo;
      end
`endif
      default: ill = 1'b1;
    endcase
  endtask

  // Issue one op, wait (bounded) for done, and check timing and outputs.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] er;
    logic eo, ei, emd;
    int lat, lowcnt;
    ref_model(o, x, y, er, eo, ei, emd);
    @(negedge clk_in);
    check_val("ready_idle", 64'(ready_out), 64'(1));
    start_in = 1'b1; alu_control_in = o; channel_a_in = x; channel_b_in = y;
    @(negedge clk_in);
    start_in = 1'b0;
    alu_control_in = 4'($urandom);
    channel_a_in = $urandom;
    channel_b_in = $urandom;
    lat = 1; lowcnt = 0;
    while (!done_out && lat < 100) begin
      if (!ready_out) lowcnt++;
      @(negedge clk_in);
      lat++;
    end
    check_val("latency", 64'(lat), 64'(emd ? W + 2 : 1));
    check_val("ready_low_cycles", 64'(lowcnt), 64'(emd ? W + 1 : 0));
    check_val("result", 64'(alu_result_out), 64'(er));
    check_val("zero", 64'(zero_out), 64'(er == 0));
    check_val("overflow", 64'(overflow_out), 64'(eo));
    check_val("illegal", 64'(illegal_out), 64'(ei));
    check_val("ready_at_done", 64'(ready_out), 64'(1));
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] er, x, y;
    logic eo, ei, emd;
    int ndone;

    reset_in = 1'b1; start_in = 1'b0; alu_control_in = 4'h0;
    channel_a_in = '0; channel_b_in = '0;
    m_hi = '0; m_lo = '0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    reset_in = 1'b0;
    check_val("rst_ready", 64'(ready_out), 64'(1));
    check_val("rst_done", 64'(done_out), 64'(0));
    check_val("rst_result", 64'(alu_result_out), 64'(0));
    check_val("rst_zero", 64'(zero_out), 64'(0));
    check_val("rst_ovf", 64'(overflow_out), 64'(0));
    check_val("rst_illegal", 64'(illegal_out), 64'(0));
    run_op(4'hD, 32'h1234, 32'h5678);                     // HI=0 after reset

    // Directed cases.
    run_op(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'h6, 32'd5, 32'd5);
    run_op(4'h7, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(4'h3, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(4'h5, 32'hAAAA_5555, 32'h1234_5678);
    run_op(4'h8, 32'hFFFF_FFFD, 32'd5);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hE, 32'h0, 32'h0);
    run_op(4'hA, 32'hFFFF_FFF9, 32'd2);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hB, 32'd10, 32'd0);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hA, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hA, 32'hFFFF_FFF9, 32'd0);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hB, 32'd10, 32'd2);
    run_op(4'hE, 32'h0, 32'h0);

    // Back-to-back single-cycle ops give a result every cycle.
    b2b_op[0] = 4'h2; b2b_op[1] = 4'h4; b2b_op[2] = 4'h1; b2b_op[3] = 4'hC;
    @(negedge clk_in);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        check_val("b2b_done", 64'(done_out), 64'(1));
        check_val("b2b_result", 64'(alu_result_out), 64'(b2b_exp[k-1]));
      end
      if (k < 4) begin
        x = $urandom; y = $urandom;
        ref_model(b2b_op[k], x, y, b2b_exp[k], eo, ei, emd);
        start_in = 1'b1; alu_control_in = b2b_op[k]; channel_a_in = x; channel_b_in = y;
      end else begin
        start_in = 1'b0;
      end
      @(negedge clk_in);
    end

    // start_in held with ADD while a MULTU runs: ignored, exactly one done.
    x = $urandom; y = $urandom;
    ref_model(4'h9, x, y, er, eo, ei, emd);
    start_in = 1'b1; alu_control_in = 4'h9; channel_a_in = x; channel_b_in = y;
    @(negedge clk_in);
    alu_control_in = 4'h2; channel_a_in = 32'd1; channel_b_in = 32'd1;
    ndone = 0;
    for (int i = 0; i < W + 8; i++) begin
      @(negedge clk_in);
      if (done_out) begin
        ndone++;
        check_val("held_start_result", 64'(alu_result_out), 64'(er));
      end
      if (ready_out) start_in = 1'b0;
    end
    start_in = 1'b0;
    check_val("held_start_done_count", 64'(ndone), 64'(1));
    run_op(4'hD, 32'h0, 32'h0);

    // Reset during iteration 10 of a MULT aborts it and clears HI/LO.
    @(negedge clk_in);
    start_in = 1'b1; alu_control_in = 4'h8; channel_a_in = $urandom | 32'h1; channel_b_in = 32'h7;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (9) @(negedge clk_in);
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    m_hi = '0; m_lo = '0;
    check_val("abort_ready", 64'(ready_out), 64'(1));
    check_val("abort_done", 64'(done_out), 64'(0));
    ndone = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk_in);
      if (done_out) ndone++;
    end
    check_val("abort_no_done", 64'(ndone), 64'(0));
    run_op(4'hD, 32'h0, 32'h0);
    run_op(4'hE, 32'h0, 32'h0);

    // Randomized ops against the model.
    for (int n = 0; n < 150; n++) begin
      run_op(4'($urandom_range(15, 0)), pick_operand(), pick_operand());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
